// File: rtl/coherence_ctrl_if.sv
// Dcache-side and RAM-side signals of the two-port coherence controller.
// The controller connects through the slave modport; caches/RAM models use master.
interface coherence_ctrl_if;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0]        cctrans;
    logic [1:0]        ccwrite;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        dwait;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  dload;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic              ramwait;

    modport slave (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramwait,
        output dwait, ccwait, ccinv, dload, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramwait,
        input  dwait, ccwait, ccinv, dload, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_ctrl.sv
// Two-dcache snooping coherence controller: arbitration, snoop, write-back, load, dirty forward (CC_FORWARD_EN).
// Latency: IDLE->ARB->SNOOP/WB1 then two RAM beats each; every RAM beat stalls while ramwait=1.
module coherence_ctrl #(
    parameter int CPUS = 2
) (
    input  logic            clk,
    input  logic            RST,
    coherence_ctrl_if.slave cc_bus
);

    typedef enum logic [3:0] {
        IDLE, ARB, SNOOP, WB1, WB2, LD1, LD2, FWD1, FWD2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_req;
    logic             r_rr;
    logic             w_snp;
    logic             w_grant;
    logic [CPUS-1:0]  w_reqs;

    logic [1:0]       w_dwait;
    logic [1:0]       w_ccwait;
    logic [1:0]       w_ccinv;
    logic [1:0][31:0] w_dload;
    logic [1:0][31:0] w_snoopaddr;
    logic             w_ramren;
    logic             w_ramwen;
    logic [31:0]      w_ramaddr;
    logic [31:0]      w_ramstore;

    assign w_reqs = cc_bus.dREN | cc_bus.dWEN;
    assign w_snp  = ~r_req;

    // r_rr names the port that wins the next tie
    always_comb begin
        w_grant = w_reqs[1];
        if (&w_reqs) begin
            w_grant = r_rr;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= IDLE;
            r_rr    <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ARB && |w_reqs) begin
                r_req <= w_grant;
                r_rr  <= ~w_grant;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (|w_reqs) w_next = ARB;
            end
            ARB: begin
                if (!(|w_reqs))
                    w_next = IDLE;
                else if (cc_bus.dWEN[w_grant] && !cc_bus.cctrans[w_grant])
                    w_next = WB1;
                else
                    w_next = SNOOP;
            end
            SNOOP: begin
                if (cc_bus.cctrans[w_snp])
                    w_next = cc_bus.ccwrite[w_snp] ? FWD1 : LD1;
            end
            WB1:  if (!cc_bus.ramwait) w_next = WB2;
            WB2:  if (!cc_bus.ramwait) w_next = IDLE;
            LD1:  if (!cc_bus.ramwait) w_next = LD2;
            LD2:  if (!cc_bus.ramwait) w_next = IDLE;
            FWD1: if (!cc_bus.ramwait) w_next = FWD2;
`ifdef CC_FORWARD_EN
            FWD2: if (!cc_bus.ramwait) w_next = IDLE;
`else
            // Without forwarding the requester re-reads the freshly written line
            FWD2: if (!cc_bus.ramwait) w_next = LD1;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_dwait     = 2'b11;
        w_ccwait    = 2'b00;
        w_ccinv     = 2'b00;
        w_dload     = '0;
        w_snoopaddr = '0;
        w_ramren    = 1'b0;
        w_ramwen    = 1'b0;
        w_ramaddr   = 32'd0;
        w_ramstore  = 32'd0;
        if (!RST) begin
            case (r_state)
                SNOOP: begin
                    w_ccwait[w_snp]    = 1'b1;
                    w_snoopaddr[w_snp] = cc_bus.daddr[r_req];
                    w_ccinv[w_snp]     = cc_bus.ccwrite[r_req];
                end
                WB1, WB2: begin
                    w_ramwen       = 1'b1;
                    w_ramaddr      = cc_bus.daddr[r_req];
                    w_ramstore     = cc_bus.dstore[r_req];
                    w_dwait[r_req] = cc_bus.ramwait;
                end
                LD1, LD2: begin
                    w_ramren       = 1'b1;
                    w_ramaddr      = cc_bus.daddr[r_req];
                    w_dload[r_req] = cc_bus.ramload;
                    w_dwait[r_req] = cc_bus.ramwait;
                end
                FWD1, FWD2: begin
                    w_ramwen       = 1'b1;
                    w_ramaddr      = cc_bus.daddr[w_snp];
                    w_ramstore     = cc_bus.dstore[w_snp];
                    w_dwait[w_snp] = cc_bus.ramwait;
`ifdef CC_FORWARD_EN
                    w_dload[r_req] = cc_bus.dstore[w_snp];
                    w_dwait[r_req] = cc_bus.ramwait;
`endif
                end
                default: ;
            endcase
        end
    end

    assign cc_bus.dwait       = w_dwait;
    assign cc_bus.ccwait      = w_ccwait;
    assign cc_bus.ccinv       = w_ccinv;
    assign cc_bus.dload       = w_dload;
    assign cc_bus.ccsnoopaddr = w_snoopaddr;
    assign cc_bus.ramREN      = w_ramren;
    assign cc_bus.ramWEN      = w_ramwen;
    assign cc_bus.ramaddr     = w_ramaddr;
    assign cc_bus.ramstore    = w_ramstore;

endmodule

// File: doc/coherence_ctrl.md
COHERENCE_CTRL -- requirements
Module: coherence_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of dcache ports; only 2 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports dREN, dWEN, cctrans, ccwrite  in  [1:0]  per-dcache read request, write request, coherence transaction, and write-intent/dirty flag.
REQ-005 SHALL have ports daddr, dstore  in  [1:0][31:0]  per-dcache word address and store data.
REQ-006 SHALL have ports dwait, ccwait, ccinv  out  [1:0]  per-dcache stall, snoop request, and invalidate.
REQ-007 SHALL have ports dload, ccsnoopaddr  out  [1:0][31:0]  per-dcache load data and snoop address.
REQ-008 SHALL have ports ramREN, ramWEN  out  1, ramaddr, ramstore  out  32, ramload  in  32, ramwait  in  1 (1 = access not complete).

Function
REQ-009 SHALL use states IDLE, ARB, SNOOP, WB1, WB2, LD1, LD2, FWD1, FWD2.
REQ-010 IDLE SHALL go to ARB when any dREN or dWEN is 1; otherwise it SHALL stay.
REQ-011 ARB SHALL grant the requesting dcache; on a two-way tie it SHALL grant the port not granted last (round-robin, initial winner 0), latching requester index R.
REQ-012 ARB SHALL go to WB1 if dWEN[R]=1 and cctrans[R]=0 (eviction write-back); otherwise it SHALL go to SNOOP.
REQ-013 SNOOP SHALL assert ccwait[S] (S = other port) with ccsnoopaddr[S]=daddr[R] and ccinv[S]=ccwrite[R], held until exit.
REQ-014 SNOOP SHALL exit on cctrans[S]=1: to FWD1 if ccwrite[S]=1, else to LD1.
REQ-015 WB1/WB2 SHALL drive ramWEN=1 and ramaddr/ramstore from daddr[R]/dstore[R], with dwait[R]=ramwait; each state SHALL advance when ramwait=0; WB2 SHALL return to IDLE.
REQ-016 LD1/LD2 SHALL drive ramREN=1, ramaddr=daddr[R], dload[R]=ramload, and dwait[R]=ramwait; each state SHALL advance when ramwait=0; LD2 SHALL return to IDLE.
REQ-017 FWD1/FWD2 SHALL forward snooper data: ramWEN=1, ramaddr=daddr[S], ramstore=dstore[S], dload[R]=dstore[S], dwait[R]=dwait[S]=ramwait; each state SHALL advance when ramwait=0; FWD2 SHALL return to IDLE.
REQ-018 dwait SHALL be 1 for every port not being serviced in the current cycle; ccwait, ccinv, ramREN, and ramWEN SHALL be 0 outside their stated states.
REQ-019 dload and ccsnoopaddr SHALL be 0 whenever not driven per REQ-013/016/017.
REQ-020 Requests arriving while not in IDLE SHALL wait; R SHALL not change until the return to IDLE.
REQ-021 A request deasserted during ARB SHALL send ARB back to IDLE without RAM access.

Reset
REQ-022 When RST=1 at a clk edge, state SHALL become IDLE and the round-robin pointer SHALL become 0, including mid-transaction.
REQ-023 During reset and in IDLE, outputs SHALL be: dwait=2'b11, ccwait=0, ccinv=0, ram*EN=0, ramaddr=0, ramstore=0, dload=0, ccsnoopaddr=0.

Configuration
REQ-024 Macro CC_FORWARD_EN SHALL select dirty-snoop handling.
REQ-025 With CC_FORWARD_EN defined, FWD1/FWD2 SHALL behave as in REQ-017.
REQ-026 Without CC_FORWARD_EN, FWD1/FWD2 SHALL write snooper data to RAM only (dload[R]=0, dwait[R]=1) and then go to LD1, which reloads from RAM.

Verification
REQ-027 Eviction: dWEN[0]=1, cctrans[0]=0, daddr 0x100/0x104, ramwait=0 -> two ramWEN cycles write 0x100 then 0x104, back to IDLE, ccwait=0 throughout.
REQ-028 Clean miss: dREN[1]=1, cctrans=1, ccwrite=0, daddr=0x200; snooper replies cctrans=1, ccwrite=0 -> ccsnoopaddr[0]=0x200, ccinv[0]=0, then LD1/LD2 from RAM with dload[1]=ramload.
REQ-029 Dirty forward (CC_FORWARD_EN): cache 0 write-miss on 0x300 (ccwrite=1); cache 1 replies ccwrite=1 with dstore 0xDEAD/0xBEEF -> ccinv[1]=1, dload[0] receives 0xDEAD then 0xBEEF, and RAM is written at the same addresses.
REQ-030 Same as REQ-029 without CC_FORWARD_EN -> RAM writes occur first, then LD1/LD2 returns 0xDEAD/0xBEEF from RAM.
REQ-031 Tie: both ports request in the same cycle twice in succession -> grant 0 then grant 1; ramwait=1 held for 3 cycles stalls the transaction with dwait=1.
REQ-032 RST=1 asserted in LD2 -> next cycle IDLE, outputs per REQ-023, and the next transaction completes normally.
